lc3_execute_out_buffer: RTL and testbench

Parametrised elastic buffer between the LC3 execute stage and the memory-access stage. It captures the complete execute-stage result bundle whenever `enable_execute` is asserted, queues up to `DEPTH` results, and presents them in order to the downstream stage over a valid/ready handshake. It adds three things the single-register execute-output path does not have:

- Configurable data/register widths and depth.
- Backpressure toward execute.
- Flush for branch redirect, plus occupancy and overflow status.

---
 rtl/lc3_exec_buf_pkg.sv | 38 +++
 rtl/lc3_sync_fifo.sv | 62 ++++++
 rtl/lc3_execute_out_buffer.sv | 105 ++++++++++
 tb/tb_lc3_execute_out_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_exec_buf_pkg.sv
// Shared widths and bundle layout for the LC3 execute-to-memory elastic buffer.
// Bundle layout from LSB: NZP, sr2, sr1, dr, M_Data, IR, alu, pc, W_Control, Mem_Control.
package lc3_exec_buf_pkg;

    localparam int unsigned LC3_DATA_W = 16;
    localparam int unsigned LC3_REG_W  = 3;
    localparam int unsigned LC3_NZP_W  = 3;
    localparam int unsigned LC3_WCTL_W = 2;

    typedef enum logic [3:0] {
        FldNzp, FldSr2, FldSr1, FldDr, FldMData, FldIr, FldAlu, FldPc, FldWCtl, FldMem
    } field_e;

    function automatic int unsigned bundle_width(input int unsigned data_w,
                                                 input int unsigned reg_w);
        return 1 + LC3_WCTL_W + 4 * data_w + 3 * reg_w + LC3_NZP_W;
    endfunction

    function automatic int unsigned field_off(input field_e f, input int unsigned data_w,
                                              input int unsigned reg_w);
        case (f)
            FldNzp:   return 0;
            FldSr2:   return LC3_NZP_W;
            FldSr1:   return LC3_NZP_W + reg_w;
            FldDr:    return LC3_NZP_W + 2 * reg_w;
            FldMData: return LC3_NZP_W + 3 * reg_w;
            FldIr:    return LC3_NZP_W + 3 * reg_w + data_w;
            FldAlu:   return LC3_NZP_W + 3 * reg_w + 2 * data_w;
            FldPc:    return LC3_NZP_W + 3 * reg_w + 3 * data_w;
            FldWCtl:  return LC3_NZP_W + 3 * reg_w + 4 * data_w;
            FldMem:   return LC3_NZP_W + 3 * reg_w + 4 * data_w + LC3_WCTL_W;
            default:  return 0;
        endcase
    endfunction

    localparam int unsigned LC3_BUNDLE_W = bundle_width(LC3_DATA_W, LC3_REG_W);

endpackage

// File: rtl/lc3_sync_fifo.sv
// Generic pointer-based synchronous FIFO with flush; pointers carry an extra wrap bit.
module lc3_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0]    fill;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign fill    = wptr_q - rptr_q;
    assign full_o  = (fill == PW'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = fill;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/lc3_execute_out_buffer.sv
// Elastic buffer between LC3 execute and memory-access stages: packs the execute bundle
// into a FIFO, presents the head over valid/ready and keeps a sticky overflow flag.
module lc3_execute_out_buffer
    import lc3_exec_buf_pkg::*;
#(
    parameter int unsigned DATA_W = LC3_DATA_W,
    parameter int unsigned REG_W  = LC3_REG_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable_execute,
    output logic                       in_ready,
    input  logic                       Mem_Control_in,
    input  logic [1:0]                 W_Control_in,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]          alu_in,
    input  logic [DATA_W-1:0]          IR_in,
    input  logic [DATA_W-1:0]          M_Data_in,
    input  logic [REG_W-1:0]           dr_in,
    input  logic [REG_W-1:0]           sr1_in,
    input  logic [REG_W-1:0]           sr2_in,
    input  logic [2:0]                 NZP_in,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       Mem_Control_out,
    output logic [1:0]                 W_Control_out,
    output logic [DATA_W-1:0]          pcout,
    output logic [DATA_W-1:0]          aluout,
    output logic [REG_W-1:0]           dr,
    output logic [REG_W-1:0]           sr1,
    output logic [REG_W-1:0]           sr2,
    output logic [DATA_W-1:0]          IR_Exec,
    output logic [2:0]                 NZP,
    output logic [DATA_W-1:0]          M_Data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int unsigned BW        = bundle_width(DATA_W, REG_W);
    localparam int unsigned OFF_NZP   = field_off(FldNzp, DATA_W, REG_W);
    localparam int unsigned OFF_SR2   = field_off(FldSr2, DATA_W, REG_W);
    localparam int unsigned OFF_SR1   = field_off(FldSr1, DATA_W, REG_W);
    localparam int unsigned OFF_DR    = field_off(FldDr, DATA_W, REG_W);
    localparam int unsigned OFF_MDATA = field_off(FldMData, DATA_W, REG_W);
    localparam int unsigned OFF_IR    = field_off(FldIr, DATA_W, REG_W);
    localparam int unsigned OFF_ALU   = field_off(FldAlu, DATA_W, REG_W);
    localparam int unsigned OFF_PC    = field_off(FldPc, DATA_W, REG_W);
    localparam int unsigned OFF_WCTL  = field_off(FldWCtl, DATA_W, REG_W);
    localparam int unsigned OFF_MEM   = field_off(FldMem, DATA_W, REG_W);

    logic [BW-1:0] bundle_in, head, head_gated;
    logic          full, empty, push, pop;
    logic          overflow_q, overflow_d;

    assign bundle_in = {Mem_Control_in, W_Control_in, pc_in, alu_in, IR_in, M_Data_in,
                        dr_in, sr1_in, sr2_in, NZP_in};

    // in_ready comes from registered pointers only, never from out_ready.
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = enable_execute & ~full;
    assign pop       = ~empty & out_ready;

    lc3_sync_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (bundle_in),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign head_gated      = head & {BW{out_valid}};
    assign Mem_Control_out = head_gated[OFF_MEM];
    assign W_Control_out   = head_gated[OFF_WCTL +: 2];
    assign pcout           = head_gated[OFF_PC +: DATA_W];
    assign aluout          = head_gated[OFF_ALU +: DATA_W];
    assign IR_Exec         = head_gated[OFF_IR +: DATA_W];
    assign M_Data          = head_gated[OFF_MDATA +: DATA_W];
    assign dr              = head_gated[OFF_DR +: REG_W];
    assign sr1             = head_gated[OFF_SR1 +: REG_W];
    assign sr2             = head_gated[OFF_SR2 +: REG_W];
    assign NZP             = head_gated[OFF_NZP +: 3];

    always_comb begin
        overflow_d = flush ? 1'b0 : (overflow_q | (enable_execute & full));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_lc3_execute_out_buffer.sv
// Bench for lc3_execute_out_buffer: directed scenarios on the default build and a random
// run on a wide build, both checked every cycle against queue-based models.
module tb_lc3_execute_out_buffer;

    localparam int unsigned AD  = 4;
    localparam int unsigned ABW = 79;
    localparam int unsigned BD  = 8;
    localparam int unsigned BDW = 32;
    localparam int unsigned BRW = 4;
    localparam int unsigned BBW = 1 + 2 + 4 * BDW + 3 * BRW + 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Default-parameter instance
    logic           reset;
    logic           a_en, a_flush, a_ordy;
    logic [ABW-1:0] a_bin;
    logic           a_in_ready, a_out_valid, a_overflow;
    logic [2:0]     a_count;
    logic           a_mem_o;
    logic [1:0]     a_wctl_o;
    logic [15:0]    a_pc_o, a_alu_o, a_ir_o, a_md_o;
    logic [2:0]     a_dr_o, a_sr1_o, a_sr2_o, a_nzp_o;
    logic [ABW-1:0] a_bout;
    assign a_bout = {a_mem_o, a_wctl_o, a_pc_o, a_alu_o, a_ir_o, a_md_o,
                     a_dr_o, a_sr1_o, a_sr2_o, a_nzp_o};

    lc3_execute_out_buffer u_dut (
        .clock           (clock),
        .reset           (reset),
        .enable_execute  (a_en),
        .in_ready        (a_in_ready),
        .Mem_Control_in  (a_bin[78]),
        .W_Control_in    (a_bin[77:76]),
        .pc_in           (a_bin[75:60]),
        .alu_in          (a_bin[59:44]),
        .IR_in           (a_bin[43:28]),
        .M_Data_in       (a_bin[27:12]),
        .dr_in           (a_bin[11:9]),
        .sr1_in          (a_bin[8:6]),
        .sr2_in          (a_bin[5:3]),
        .NZP_in          (a_bin[2:0]),
        .flush           (a_flush),
        .out_valid       (a_out_valid),
        .out_ready       (a_ordy),
        .Mem_Control_out (a_mem_o),
        .W_Control_out   (a_wctl_o),
        .pcout           (a_pc_o),
        .aluout          (a_alu_o),
        .dr              (a_dr_o),
        .sr1             (a_sr1_o),
        .sr2             (a_sr2_o),
        .IR_Exec         (a_ir_o),
        .NZP             (a_nzp_o),
        .M_Data          (a_md_o),
        .count           (a_count),
        .overflow        (a_overflow)
    );

    // Wide instance for the parameter sweep
    logic           reset_b;
    logic           b_en, b_flush, b_ordy;
    logic [BBW-1:0] b_bin;
    logic           b_in_ready, b_out_valid, b_overflow;
    logic [3:0]     b_count;
    logic           b_mem_o;
    logic [1:0]     b_wctl_o;
    logic [31:0]    b_pc_o, b_alu_o, b_ir_o, b_md_o;
    logic [3:0]     b_dr_o, b_sr1_o, b_sr2_o;
    logic [2:0]     b_nzp_o;
    logic [BBW-1:0] b_bout;
    assign b_bout = {b_mem_o, b_wctl_o, b_pc_o, b_alu_o, b_ir_o, b_md_o,
                     b_dr_o, b_sr1_o, b_sr2_o, b_nzp_o};

    lc3_execute_out_buffer #(
        .DATA_W (BDW),
        .REG_W  (BRW),
        .DEPTH  (BD)
    ) u_dut_w (
        .clock           (clock),
        .reset           (reset_b),
        .enable_execute  (b_en),
        .in_ready        (b_in_ready),
        .Mem_Control_in  (b_bin[145]),
        .W_Control_in    (b_bin[144:143]),
        .pc_in           (b_bin[142:111]),
        .alu_in          (b_bin[110:79]),
        .IR_in           (b_bin[78:47]),
        .M_Data_in       (b_bin[46:15]),
        .dr_in           (b_bin[14:11]),
        .sr1_in          (b_bin[10:7]),
        .sr2_in          (b_bin[6:3]),
        .NZP_in          (b_bin[2:0]),
        .flush           (b_flush),
        .out_valid       (b_out_valid),
        .out_ready       (b_ordy),
        .Mem_Control_out (b_mem_o),
        .W_Control_out   (b_wctl_o),
        .pcout           (b_pc_o),
        .aluout          (b_alu_o),
        .dr              (b_dr_o),
        .sr1             (b_sr1_o),
        .sr2             (b_sr2_o),
        .IR_Exec         (b_ir_o),
        .NZP             (b_nzp_o),
        .M_Data          (b_md_o),
        .count           (b_count),
        .overflow        (b_overflow)
    );

    logic [ABW-1:0] qa[$];
    logic [BBW-1:0] qb[$];
    bit             ovf_a = 1'b0;
    bit             ovf_b = 1'b0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [ABW-1:0] mk_a(input logic [15:0] pc, input logic [15:0] alu,
                                            input logic [2:0] dr_v, input logic [2:0] nzp_v,
                                            input logic [1:0] wctl);
        return {1'b0, wctl, pc, alu, 16'h0, 16'h0, dr_v, 3'b0, 3'b0, nzp_v};
    endfunction

    // Queue semantics: flush clears; a full queue refuses the push; a non-empty head pops.
    task automatic model_a_edge();
        bit was_full;
        bit do_pop;
        if (a_flush) begin
            qa.delete();
            ovf_a = 1'b0;
        end else begin
            was_full = (qa.size() == AD);
            do_pop   = (qa.size() != 0) && a_ordy;
            if (a_en && was_full)  ovf_a = 1'b1;
            if (a_en && !was_full) qa.push_back(a_bin);
            if (do_pop) void'(qa.pop_front());
        end
    endtask

    task automatic model_b_edge();
        bit was_full;
        bit do_pop;
        if (b_flush) begin
            qb.delete();
            ovf_b = 1'b0;
        end else begin
            was_full = (qb.size() == BD);
            do_pop   = (qb.size() != 0) && b_ordy;
            if (b_en && was_full)  ovf_b = 1'b1;
            if (b_en && !was_full) qb.push_back(b_bin);
            if (do_pop) void'(qb.pop_front());
        end
    endtask

    task automatic check_a();
        chk("a_count", a_count, qa.size());
        chk("a_out_valid", a_out_valid, qa.size() != 0);
        chk("a_in_ready", a_in_ready, qa.size() < AD);
        chk("a_overflow", a_overflow, ovf_a);
        chk("a_head", a_bout, (qa.size() != 0) ? qa[0] : '0);
    endtask

    task automatic check_b();
        chk("b_count", b_count, qb.size());
        chk("b_out_valid", b_out_valid, qb.size() != 0);
        chk("b_in_ready", b_in_ready, qb.size() < BD);
        chk("b_overflow", b_overflow, ovf_b);
        chk("b_head", b_bout, (qb.size() != 0) ? qb[0] : '0);
    endtask

    task automatic tick_a();
        model_a_edge();
        @(posedge clock);
        #1;
        check_a();
    endtask

    task automatic tick_b();
        model_b_edge();
        @(posedge clock);
        #1;
        check_b();
    endtask

    initial begin
        int bias;
        reset   = 1'b0;
        reset_b = 1'b0;
        a_en = 1'b0; a_flush = 1'b0; a_ordy = 1'b0; a_bin = '0;
        b_en = 1'b0; b_flush = 1'b0; b_ordy = 1'b0; b_bin = '0;
        #2;
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_count", a_count, 3'd0);
        chk("rst_overflow", a_overflow, 1'b0);
        chk("rst_head", a_bout, '0);
        chk("rst_b_in_ready", b_in_ready, 1'b1);
        #10;
        reset   = 1'b1;
        reset_b = 1'b1;
        tick_a();

        // Single entry
        a_bin = mk_a(16'h3001, 16'h00FF, 3'd3, 3'b001, 2'b01);
        a_en  = 1'b1;
        tick_a();
        a_en = 1'b0;
        chk("single_valid", a_out_valid, 1'b1);
        chk("single_count", a_count, 3'd1);
        chk("single_pc", a_pc_o, 16'h3001);
        chk("single_alu", a_alu_o, 16'h00FF);
        chk("single_dr", a_dr_o, 3'd3);
        chk("single_nzp", a_nzp_o, 3'b001);
        chk("single_wctl", a_wctl_o, 2'b01);
        a_ordy = 1'b1;
        tick_a();
        a_ordy = 1'b0;
        chk("single_pop_valid", a_out_valid, 1'b0);
        chk("single_pop_head", a_bout, '0);

        // Fill and overflow
        for (int i = 0; i < 5; i++) begin
            a_bin = mk_a(16'h3000 + 16'(i), 16'h0, 3'd0, 3'b010, 2'b00);
            a_en  = 1'b1;
            tick_a();
            if (i == 3) begin
                chk("fill_count4", a_count, 3'd4);
                chk("fill_in_ready0", a_in_ready, 1'b0);
                chk("fill_ovf_clear", a_overflow, 1'b0);
            end
        end
        a_en = 1'b0;
        chk("fill_overflow", a_overflow, 1'b1);
        chk("fill_count_held", a_count, 3'd4);
        a_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order_pc", a_pc_o, 16'h3000 + 16'(i));
            tick_a();
        end
        a_ordy = 1'b0;
        chk("drain_empty", a_out_valid, 1'b0);
        chk("drain_ovf_sticky", a_overflow, 1'b1);

        // Concurrent push/pop at full
        for (int i = 0; i < 4; i++) begin
            a_bin = mk_a(16'h3100 + 16'(i), 16'h1234, 3'd5, 3'b100, 2'b10);
            a_en  = 1'b1;
            tick_a();
        end
        a_ordy = 1'b1;
        a_bin  = mk_a(16'h3104, 16'h0, 3'd1, 3'b001, 2'b11);
        tick_a();
        chk("full_pp_count3", a_count, 3'd3);
        chk("full_pp_ovf", a_overflow, 1'b1);
        chk("full_pp_head", a_pc_o, 16'h3101);
        tick_a();
        chk("pp_count_stays3", a_count, 3'd3);

        // Flush beats push and pop
        a_flush = 1'b1;
        tick_a();
        a_flush = 1'b0; a_en = 1'b0; a_ordy = 1'b0;
        chk("flush_count", a_count, 3'd0);
        chk("flush_valid", a_out_valid, 1'b0);
        chk("flush_ovf", a_overflow, 1'b0);
        chk("flush_in_ready", a_in_ready, 1'b1);

        // Asynchronous reset between edges
        a_en = 1'b1;
        a_bin = mk_a(16'h4000, 16'h0, 3'd2, 3'b010, 2'b01);
        tick_a();
        a_bin = mk_a(16'h4001, 16'h0, 3'd2, 3'b010, 2'b01);
        tick_a();
        a_en = 1'b0;
        chk("pre_arst_count", a_count, 3'd2);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid", a_out_valid, 1'b0);
        chk("arst_count", a_count, 3'd0);
        chk("arst_in_ready", a_in_ready, 1'b1);
        chk("arst_head", a_bout, '0);
        qa.delete();
        ovf_a = 1'b0;
        #2;
        reset = 1'b1;
        a_bin = mk_a(16'h4100, 16'hBEEF, 3'd6, 3'b100, 2'b10);
        a_en  = 1'b1;
        tick_a();
        a_en = 1'b0;
        chk("post_arst_valid", a_out_valid, 1'b1);
        chk("post_arst_pc", a_pc_o, 16'h4100);
        chk("post_arst_alu", a_alu_o, 16'hBEEF);

        // Random traffic on the default build
        for (int i = 0; i < 400; i++) begin
            bias    = ((i / 50) % 2 != 0) ? 85 : 30;
            a_en    = ($urandom_range(0, 99) < bias);
            a_ordy  = ($urandom_range(0, 99) < 55);
            a_flush = ($urandom_range(0, 79) == 0);
            a_bin   = ABW'({$urandom(), $urandom(), $urandom()});
            tick_a();
        end
        a_en = 1'b0; a_ordy = 1'b0; a_flush = 1'b0;

        // Parameter sweep: wide build, random traffic
        tick_b();
        for (int i = 0; i < 10000; i++) begin
            bias    = ((i / 100) % 2 != 0) ? 80 : 35;
            b_en    = ($urandom_range(0, 99) < bias);
            b_ordy  = ($urandom_range(0, 99) < 55);
            b_flush = ($urandom_range(0, 199) == 0);
            b_bin   = BBW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            tick_b();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
